// File: rtl/jt1943_rom_pkg.sv
// Shared constants for the 1943 SDRAM ROM map and the arbiter's default channel layout.
// ROM region offsets are added by the instantiating top; the arbiter only sees absolute addresses.
package jt1943_rom_pkg;

    localparam int ROM_CH = 7;
    localparam int ROM_AW = 22;

    localparam logic [21:0] SND_OFFSET  = 22'h14000;
    localparam logic [21:0] CHAR_OFFSET = 22'h18000;
    localparam logic [21:0] MAP1_OFFSET = 22'h1C000;
    localparam logic [21:0] MAP2_OFFSET = 22'h20000;
    localparam logic [21:0] SCR1_OFFSET = 22'h24000;
    localparam logic [21:0] SCR2_OFFSET = 22'h44000;
    localparam logic [21:0] OBJ_OFFSET  = 22'h4C000;
    localparam logic [21:0] ROM_LEN     = 22'h6C000;

    localparam int CH_MAIN = 0;
    localparam int CH_SND  = 1;
    localparam int CH_CHAR = 2;
    localparam int CH_MAP  = 3;
    localparam int CH_SCR1 = 4;
    localparam int CH_SCR2 = 5;
    localparam int CH_OBJ  = 6;

endpackage

// File: rtl/jt1943_rom_pick.sv
// Combinational channel picker: lowest-index eligible channel, or round robin
// starting just after the last winner.
module jt1943_rom_pick #(
    parameter int CH = 7,
    parameter int RR = 0,
    parameter int IW = $clog2(CH)
) (
    input  logic [CH-1:0] i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [CH-1:0] o_oh,
    output logic [IW-1:0] o_idx,
    output logic          o_hit
);

    // One spare bit so ptr+1+k can exceed CH before the single wrap subtraction.
    logic [IW:0] w_j;

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_j   = '0;
        for (int k = 0; k < CH; k++) begin
            if (RR != 0) w_j = {1'b0, i_ptr} + (IW+1)'(1) + (IW+1)'(k);
            else         w_j = (IW+1)'(k);
            if (w_j >= (IW+1)'(CH)) w_j = w_j - (IW+1)'(CH);
            if (!o_hit && i_elig[w_j[IW-1:0]]) begin
                o_hit = 1'b1;
                o_idx = w_j[IW-1:0];
            end
        end
        o_oh = o_hit ? (CH'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/jt1943_rom_arb.sv
// SDRAM ROM arbiter: grants one request channel per cen onto a shared read port and
// returns a one-hot data strobe LAT cens later, never granting a channel twice per fetch.
module jt1943_rom_arb
    import jt1943_rom_pkg::*;
#(
    parameter int CH      = ROM_CH,
    parameter int AW      = ROM_AW,
    parameter int LAT     = 2,
    parameter int RR      = 0,
    parameter int RDY_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cen,
    input  logic             i_downloading,
    input  logic             i_loop_rst,
    input  logic [CH-1:0]    i_ch_req,
    input  logic [CH*AW-1:0] i_ch_addr,
    output logic [CH-1:0]    o_ch_ack,
    output logic [CH-1:0]    o_ch_we,
    output logic [AW-1:0]    o_sdram_addr,
    output logic             o_sdram_re,
    output logic             o_ready,
    output logic             o_busy
);

    localparam int IW = $clog2(CH);
    localparam int PL = (LAT == 0) ? 1 : LAT;

    logic                     w_halt;
    logic [CH-1:0][AW-1:0]    w_addr;
    logic [CH-1:0]            w_elig, w_win_oh, w_del_oh;
    logic [IW-1:0]            w_win_idx, w_del_idx;
    logic                     w_hit, w_del_vld;

    logic [CH-1:0]            r_ack, r_we, r_inflight;
    logic [AW-1:0]            r_addr;
    logic                     r_re;
    logic [IW-1:0]            r_ptr;
    logic [PL-1:0]            r_vld_pipe;
    logic [PL-1:0][IW-1:0]    r_idx_pipe;
    logic [RDY_CNT-1:0]       r_rdy_sr;

    assign w_halt = i_rst | i_loop_rst | i_downloading;
    assign w_addr = i_ch_addr;
    assign w_elig = i_ch_req & ~r_inflight;

    jt1943_rom_pick #(.CH(CH), .RR(RR), .IW(IW)) u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_oh   (w_win_oh),
        .o_idx  (w_win_idx),
        .o_hit  (w_hit)
    );

    // With no latency the grant itself is the delivery.
    assign w_del_vld = (LAT == 0) ? w_hit     : r_vld_pipe[PL-1];
    assign w_del_idx = (LAT == 0) ? w_win_idx : r_idx_pipe[PL-1];
    assign w_del_oh  = w_del_vld ? (CH'(1) << w_del_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (w_halt) begin
            r_ack      <= '0;
            r_we       <= '0;
            r_inflight <= '0;
            r_addr     <= '0;
            r_re       <= 1'b0;
            r_ptr      <= IW'(CH-1);
            r_vld_pipe <= '0;
            r_idx_pipe <= '0;
            r_rdy_sr   <= '0;
        end else if (i_cen) begin
            r_re  <= ~r_re;
            r_ack <= w_win_oh;
            r_we  <= w_del_oh;
            if (w_hit) begin
                r_addr <= w_addr[w_win_idx];
                r_ptr  <= w_win_idx;
            end
            // Set after clear: a same-update regrant keeps the channel in flight.
            r_inflight <= (LAT == 0) ? '0 : ((r_inflight & ~w_del_oh) | w_win_oh);
            for (int i = PL-1; i > 0; i--) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            r_vld_pipe[0] <= w_hit;
            r_idx_pipe[0] <= w_win_idx;
            r_rdy_sr      <= (r_rdy_sr << 1) | RDY_CNT'(1);
        end
    end

    assign o_ch_ack     = r_ack;
    assign o_ch_we      = r_we;
    assign o_sdram_addr = r_addr;
    assign o_sdram_re   = r_re;
    assign o_ready      = r_rdy_sr[RDY_CNT-1];
    assign o_busy       = (LAT == 0) ? 1'b0 : |r_vld_pipe;

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// Scoreboard bench: three arbiter configurations share clk/cen; expected grants and
// deliveries are queued by the stimulus and matched by a monitor on every cen edge.
module tb_jt1943_rom_arb;

    localparam int AW = 22;

    logic clk = 1'b0;
    logic rst, cen;
    always #5 clk = ~clk;

    // A: CH=7 LAT=2 fixed; B: CH=4 LAT=0 round robin; C: CH=7 LAT=3 round robin
    logic a_dl, a_lr, b_dl, b_lr, c_dl, c_lr;
    logic [6:0] a_req, c_req;
    logic [3:0] b_req;
    logic [7*AW-1:0] a_addr, c_addr;
    logic [4*AW-1:0] b_addr;
    logic [6:0] a_ack, a_we, c_ack, c_we;
    logic [3:0] b_ack, b_we;
    logic [AW-1:0] a_sa, b_sa, c_sa;
    logic a_re, a_rdy, a_busy, b_re, b_rdy, b_busy, c_re, c_rdy, c_busy;

    jt1943_rom_arb #(.CH(7), .AW(AW), .LAT(2), .RR(0), .RDY_CNT(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_downloading(a_dl), .i_loop_rst(a_lr),
        .i_ch_req(a_req), .i_ch_addr(a_addr), .o_ch_ack(a_ack), .o_ch_we(a_we),
        .o_sdram_addr(a_sa), .o_sdram_re(a_re), .o_ready(a_rdy), .o_busy(a_busy));

    jt1943_rom_arb #(.CH(4), .AW(AW), .LAT(0), .RR(1), .RDY_CNT(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_downloading(b_dl), .i_loop_rst(b_lr),
        .i_ch_req(b_req), .i_ch_addr(b_addr), .o_ch_ack(b_ack), .o_ch_we(b_we),
        .o_sdram_addr(b_sa), .o_sdram_re(b_re), .o_ready(b_rdy), .o_busy(b_busy));

    jt1943_rom_arb #(.CH(7), .AW(AW), .LAT(3), .RR(1), .RDY_CNT(4)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_downloading(c_dl), .i_loop_rst(c_lr),
        .i_ch_req(c_req), .i_ch_addr(c_addr), .o_ch_ack(c_ack), .o_ch_we(c_we),
        .o_sdram_addr(c_sa), .o_sdram_re(c_re), .o_ready(c_rdy), .o_busy(c_busy));

    logic [15:0]   m_ack [3];
    logic [15:0]   m_we  [3];
    logic [AW-1:0] m_sa  [3];
    assign m_ack[0] = 16'(a_ack); assign m_we[0] = 16'(a_we); assign m_sa[0] = a_sa;
    assign m_ack[1] = 16'(b_ack); assign m_we[1] = 16'(b_we); assign m_sa[1] = b_sa;
    assign m_ack[2] = 16'(c_ack); assign m_we[2] = 16'(c_we); assign m_sa[2] = c_sa;

    typedef struct {
        int            dut;
        int            cen;
        bit            we;
        logic [15:0]   oh;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ecount = 0;
    int   mk;

    task automatic push(input int d, input int k, input bit w, input logic [15:0] oh,
                        input logic [AW-1:0] a);
        exp_t e;
        e.dut = d; e.cen = k; e.we = w; e.oh = oh; e.addr = a;
        sbq.push_back(e);
    endtask

    task automatic match(input int d, input bit w, input int k, input logic [15:0] oh,
                         input logic [AW-1:0] a);
        int pos;
        pos = -1;
        for (int i = 0; i < sbq.size(); i++)
            if (pos < 0 && sbq[i].dut == d && sbq[i].we == w) pos = i;
        n_cmp++;
        if (pos < 0) begin
            n_bad++;
            $display("FAIL unexpected_%s dut%0d cen %0d: got %h, wanted nothing", w ? "we" : "ack", d, k, oh);
        end else begin
            if (sbq[pos].cen != k || sbq[pos].oh != oh || (!w && sbq[pos].addr != a)) begin
                n_bad++;
                $display("FAIL %s dut%0d: got cen %0d oh %h addr %h, want cen %0d oh %h addr %h",
                         w ? "we" : "ack", d, k, oh, a, sbq[pos].cen, sbq[pos].oh, sbq[pos].addr);
            end
            sbq.delete(pos);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Monitor: numbers every cen edge and matches any grant/delivery against the queue.
    always begin
        @(posedge clk);
        if (cen) begin
            mk = ecount;
            ecount++;
            #2;
            for (int d = 0; d < 3; d++) begin
                if (m_ack[d] != 16'd0) match(d, 1'b0, mk, m_ack[d], m_sa[d]);
                if (m_we[d]  != 16'd0) match(d, 1'b1, mk, m_we[d],  m_sa[d]);
            end
        end
    end

    task automatic step();
        cen = 1'b1;
        @(posedge clk); #1 cen = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int e;
        rst = 1'b1; cen = 1'b0;
        a_dl = 0; a_lr = 0; b_dl = 0; b_lr = 0; c_dl = 0; c_lr = 0;
        a_req = '0; b_req = '0; c_req = '0;
        a_addr = '0; b_addr = '0; c_addr = '0;

        repeat (3) begin
            step();
            chk("rst_outs_a", 64'({a_ack, a_we, a_sa, a_re, a_rdy, a_busy}), 64'd0);
            chk("rst_outs_c", 64'({c_ack, c_we, c_sa, c_re, c_rdy, c_busy}), 64'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("sdram_re", 64'(a_re), 64'(i % 2));
            chk("ready_rise", 64'(a_rdy), 64'(i >= 4));
        end

        // Fixed priority, LAT=2, ch1+ch2 held, then dropped with two fetches in flight
        a_addr[1*AW +: AW] = 22'h14001;
        a_addr[2*AW +: AW] = 22'h18002;
        a_req = 7'b0000110;
        e = ecount;
        push(0, e,   0, 16'h2, 22'h14001); push(0, e+1, 0, 16'h4, 22'h18002);
        push(0, e+3, 0, 16'h2, 22'h14001); push(0, e+4, 0, 16'h4, 22'h18002);
        push(0, e+2, 1, 16'h2, '0); push(0, e+3, 1, 16'h4, '0);
        push(0, e+5, 1, 16'h2, '0); push(0, e+6, 1, 16'h4, '0);
        step();
        chk("busy_a", 64'(a_busy), 64'd1);
        repeat (4) step();
        a_req = '0;
        repeat (4) step();
        chk("busy_a_idle", 64'(a_busy), 64'd0);

        // Download halt with a pending request, then release
        a_dl = 1'b1;
        a_req = 7'b0000001;
        a_addr[0 +: AW] = 22'h00123;
        repeat (100) begin
            step();
            chk("dl_re", 64'(a_re), 64'd0);
            chk("dl_ack", 64'(a_ack), 64'd0);
        end
        a_dl = 1'b0;
        e = ecount;
        push(0, e, 0, 16'h1, 22'h00123);
        push(0, e+2, 1, 16'h1, '0);
        step();
        a_req = '0;
        chk("dl_ready1", 64'(a_rdy), 64'd0);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk("dl_ready", 64'(a_rdy), 64'(i >= 4));
        end

        // Round robin, LAT=0, all four channels requesting
        for (int i = 0; i < 4; i++) b_addr[i*AW +: AW] = 22'h18000 + 22'(i);
        b_req = 4'hF;
        e = ecount;
        for (int k = 0; k < 5; k++) begin
            push(1, e+k, 0, 16'h1 << (k % 4), 22'h18000 + 22'(k % 4));
            push(1, e+k, 1, 16'h1 << (k % 4), '0);
        end
        repeat (5) step();
        b_req = '0;
        repeat (2) step();

        // LAT=3, single channel 5 held continuously
        c_addr[5*AW +: AW] = 22'h4C123;
        c_req = 7'b0100000;
        e = ecount;
        for (int k = 0; k < 3; k++) begin
            push(2, e + 4*k, 0, 16'h20, 22'h4C123);
            push(2, e + 4*k + 3, 1, 16'h20, '0);
        end
        repeat (9) step();
        c_req = '0;
        repeat (4) step();
        chk("busy_c_idle", 64'(c_busy), 64'd0);

        // loop_rst flushes two in-flight fetches and resets the RR pointer
        c_addr[0*AW +: AW] = 22'h00AA0;
        c_addr[1*AW +: AW] = 22'h00BB1;
        c_addr[3*AW +: AW] = 22'h00CC3;
        c_req = 7'b0000011;
        e = ecount;
        push(2, e, 0, 16'h1, 22'h00AA0);
        push(2, e+1, 0, 16'h2, 22'h00BB1);
        repeat (2) step();
        chk("busy_c_inflight", 64'(c_busy), 64'd1);
        c_req = '0;
        c_lr = 1'b1;
        repeat (3) step();
        chk("flush_busy", 64'(c_busy), 64'd0);
        chk("flush_we", 64'(c_we), 64'd0);
        chk("flush_ready", 64'(c_rdy), 64'd0);
        c_lr = 1'b0;
        c_req = 7'b0001001;
        e = ecount;
        push(2, e, 0, 16'h1, 22'h00AA0);
        push(2, e+1, 0, 16'h8, 22'h00CC3);
        push(2, e+3, 1, 16'h1, '0);
        push(2, e+4, 1, 16'h8, '0);
        repeat (2) step();
        c_req = '0;
        repeat (4) step();

        foreach (sbq[i])
            $display("leftover expectation: dut%0d cen %0d we %0d oh %h", sbq[i].dut, sbq[i].cen, sbq[i].we, sbq[i].oh);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
